// File: rtl/rtc_pkg.sv
// Shared types and constants for the I2C RTC register synchroniser.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    PH_WRITE,
    PH_SCAN,
    PH_VERIFY
  } phase_t;

  // i2c_master status word bit positions
  localparam int unsigned STAT_BUSY  = 31;
  localparam int unsigned STAT_READY = 28;

  // MCP7940N: strips ST/OSCRUN/VBATEN/leap/12-24 control bits from the time registers
  localparam logic [55:0] MCP7940N_MASK = 56'hFF_1F_3F_07_3F_7F_7F;

endpackage

// File: rtl/rtc_reg_sync.sv
// Periodically burst-reads an I2C RTC through i2c_master, verifies coherence by
// re-reading the first register, commits the snapshot atomically, and serves host writes.
module rtc_reg_sync
  import rtc_pkg::*;
#(
  parameter int unsigned         C_CLK_MHZ   = 25,
  parameter logic [6:0]          C_DEV_ADDR  = 7'h6F,
  parameter int unsigned         C_FIRST_REG = 0,
  parameter int unsigned         C_NREGS     = 7,
  parameter logic [8*C_NREGS-1:0] C_MASK     = (8*C_NREGS)'(MCP7940N_MASK),
  parameter int unsigned         C_POLL_MS   = 250,
  parameter int unsigned         C_TIMEOUT   = 1 << 20,
  parameter int unsigned         C_RETRIES   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [31:0]            ctrl_data,
  output logic                   wr_ctrl,
  input  logic [31:0]            status,
  input  logic                   set_req,
  input  logic [8*C_NREGS-1:0]   datetime_i,
  output logic                   set_ack,
  output logic [8*C_NREGS-1:0]   datetime_o,
  output logic                   valid,
  output logic                   tick,
  output logic                   busy_o,
  output logic                   err
);

  localparam int unsigned DT_W     = 8 * C_NREGS;
  localparam int unsigned POLL_MAX = C_CLK_MHZ * 1000 * C_POLL_MS - 1;
  localparam int unsigned POLL_W   = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;
  localparam int unsigned TMO_W    = $clog2(C_TIMEOUT + 1);
  localparam int unsigned IDX_W    = (C_NREGS > 1) ? $clog2(C_NREGS) : 1;
  localparam int unsigned RTY_W    = (C_RETRIES > 0) ? $clog2(C_RETRIES + 1) : 1;

  state_t              state;
  phase_t              phase;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                idx_last;
  logic [7:0]          shadow [C_NREGS];
  logic [DT_W-1:0]     snap_masked;
  logic [DT_W-1:0]     dt_lat;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic [RTY_W-1:0]    retry_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic                poll_wrap;
  logic                scan_pend;
  logic                set_pend;
  logic                vmatch;
  logic                unused_status;

  assign unused_status = ^{status[30:29], status[27:8]};

  assign idx_nxt   = idx + 1'b1;
  assign idx_last  = (idx == IDX_W'(C_NREGS - 1));
  assign tmo_hit   = (tmo_cnt == TMO_W'(C_TIMEOUT - 1));
  assign poll_wrap = (poll_cnt == POLL_W'(POLL_MAX));

  function automatic logic [7:0] reg_addr(input logic [IDX_W-1:0] i);
    return 8'(C_FIRST_REG) + 8'(i);
  endfunction

  function automatic logic [31:0] make_cmd(input logic rd, input logic [7:0] ra,
                                           input logic [7:0] wd);
    return {rd, 8'h00, C_DEV_ADDR, ra, wd};
  endfunction

  // Shadow with the per-register mask applied, ready for a single-edge commit
  always_comb begin
    snap_masked = '0;
    for (int k = 0; k < int'(C_NREGS); k++) begin
      snap_masked[8*k +: 8] = shadow[k] & C_MASK[8*k +: 8];
    end
  end

  // Free-running poll divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Command sequencer; wr_ctrl/ctrl_data are loaded on the edge entering ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= PH_SCAN;
      idx        <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      scan_pend  <= 1'b0;
      set_pend   <= 1'b0;
      vmatch     <= 1'b0;
      dt_lat     <= '0;
      for (int k = 0; k < int'(C_NREGS); k++) shadow[k] <= '0;
      ctrl_data  <= '0;
      wr_ctrl    <= 1'b0;
      set_ack    <= 1'b0;
      datetime_o <= '0;
      valid      <= 1'b0;
      tick       <= 1'b0;
      busy_o     <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_ctrl <= 1'b0;
      set_ack <= 1'b0;
      valid   <= 1'b0;
      tick    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (set_pend) begin
            set_pend  <= 1'b0;
            phase     <= PH_WRITE;
            idx       <= '0;
            dt_lat    <= datetime_i;
            ctrl_data <= make_cmd(1'b0, reg_addr('0), datetime_i[7:0]);
            wr_ctrl   <= 1'b1;
            busy_o    <= 1'b1;
            state     <= ST_ISSUE;
          end else if (scan_pend) begin
            scan_pend <= 1'b0;
            phase     <= PH_SCAN;
            idx       <= '0;
            retry_cnt <= '0;
            ctrl_data <= make_cmd(1'b1, reg_addr('0), 8'h00);
            wr_ctrl   <= 1'b1;
            busy_o    <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (status[STAT_BUSY]) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_hit) begin
            err    <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!status[STAT_BUSY]) begin
            if (phase != PH_WRITE && !status[STAT_READY]) begin
              err    <= 1'b1;
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              if (phase == PH_SCAN)   shadow[idx] <= status[7:0];
              if (phase == PH_VERIFY) vmatch      <= (status[7:0] == shadow[0]);
              state <= ST_NEXT;
            end
          end else if (tmo_hit) begin
            err    <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_NEXT: begin
          case (phase)
            PH_WRITE: begin
              if (idx_last) begin
                set_ack   <= 1'b1;
                scan_pend <= 1'b1;
                busy_o    <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                idx       <= idx_nxt;
                ctrl_data <= make_cmd(1'b0, reg_addr(idx_nxt), dt_lat[{idx_nxt, 3'b000} +: 8]);
                wr_ctrl   <= 1'b1;
                state     <= ST_ISSUE;
              end
            end
            PH_SCAN: begin
              if (idx_last) begin
                phase     <= PH_VERIFY;
                ctrl_data <= make_cmd(1'b1, reg_addr('0), 8'h00);
              end else begin
                idx       <= idx_nxt;
                ctrl_data <= make_cmd(1'b1, reg_addr(idx_nxt), 8'h00);
              end
              wr_ctrl <= 1'b1;
              state   <= ST_ISSUE;
            end
            default: state <= ST_CHECK;
          endcase
        end

        ST_CHECK: begin
          if (vmatch) begin
            datetime_o <= snap_masked;
            valid      <= 1'b1;
            tick       <= (snap_masked[7:0] != datetime_o[7:0]);
            err        <= 1'b0;
            retry_cnt  <= '0;
            state      <= ST_COMMIT;
          end else if (retry_cnt < RTY_W'(C_RETRIES)) begin
            retry_cnt <= retry_cnt + 1'b1;
            phase     <= PH_SCAN;
            idx       <= '0;
            ctrl_data <= make_cmd(1'b1, reg_addr('0), 8'h00);
            wr_ctrl   <= 1'b1;
            state     <= ST_ISSUE;
          end else begin
            err    <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_COMMIT: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase

      // Late assignments so a new request or wrap is never lost to a same-cycle clear
      if (set_req)   set_pend  <= 1'b1;
      if (poll_wrap) scan_pend <= 1'b1;
    end
  end

endmodule
